// File: rtl/uart_echo_responder.sv
// uart_echo_responder: buffers bytes received by a Uart8 core in a small FIFO
// and echoes them back through the Uart8 transmitter, one at a time.
// Bytes with frame errors can be dropped. Bytes that arrive when the FIFO is
// full are dropped. An echo is abandoned if the transmitter never starts.
module uart_echo_responder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 4096,
  parameter bit DROP_ERR      = 1'b1
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       en,
  input  logic       rxDone,
  input  logic       rxErr,
  input  logic [7:0] rxByte,
  input  logic       txBusy,
  output logic       txStart,
  output logic [7:0] txByte,
  output logic [7:0] rxCount,
  output logic [7:0] dropCount,
  output logic [4:0] fifoLevel,
  output logic       timeoutErr
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            TW      = $clog2(START_TIMEOUT + 1);
  localparam logic [4:0]    DEPTH_L = 5'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_rx_done_q;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [4:0]      r_level;
  logic [7:0]      r_rx_count;
  logic [7:0]      r_drop_count;
  logic [TW-1:0]   r_to_cnt;
  logic [7:0]      r_tx_byte;
  logic            r_timeout;

  logic            w_rx_edge;
  logic            w_err_drop;
  logic            w_cap_ok;
  logic            w_push;
  logic            w_overflow;
  logic            w_pop;
  logic            w_timeout;
  logic [1:0]      w_drop_inc;
  logic [8:0]      w_drop_sum;

  // A new frame is seen only on the rising edge of rxDone. A level-high
  // rxDone does not capture again.
  assign w_rx_edge  = en & rxDone & ~r_rx_done_q;
  assign w_err_drop = w_rx_edge & rxErr & DROP_ERR;
  assign w_cap_ok   = w_rx_edge & ~w_err_drop;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_push     = w_cap_ok & ((r_level != DEPTH_L) | w_pop);
  assign w_overflow = w_cap_ok & ~w_push;

  // A lost frame and a timeout can land in the same cycle. Both are counted.
  assign w_drop_inc = {1'b0, w_err_drop | w_overflow} + {1'b0, w_timeout};
  assign w_drop_sum = {1'b0, r_drop_count} + {7'd0, w_drop_inc};

  assign txStart    = (r_state == START);
  assign txByte     = r_tx_byte;
  assign rxCount    = r_rx_count;
  assign dropCount  = r_drop_count;
  assign fifoLevel  = r_level;
  assign timeoutErr = r_timeout;

  // Transmit FSM: next state, pop request and timeout detection.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, or
    // the paths that skip an assignment infer a latch.
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && (r_level != 5'd0) && !txBusy) begin
          w_next_state = START;
          w_pop        = 1'b1;
        end
      end
      START: begin
        if (txBusy) begin
          w_next_state = WAIT;
        end else if (r_to_cnt == TO_LAST) begin
          w_next_state = IDLE;
          w_timeout    = 1'b1;
        end
      end
      WAIT: begin
        if (!txBusy) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM state, the START timeout counter and the timeout pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together and there is no race on evaluation order.
    if (!rstN) begin
      r_state   <= IDLE;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_to_cnt  <= (r_state == START && w_next_state == START) ? r_to_cnt + 1'b1 : '0;
      r_timeout <= w_timeout;
    end
  end

  // rxDone edge register, FIFO pointers and level, and the outgoing byte.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_rx_done_q <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= 5'd0;
      r_tx_byte   <= 8'd0;
    end else begin
      r_rx_done_q <= rxDone;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_byte <= r_mem[r_rd_ptr];
      end
      r_level <= r_level + {4'd0, w_push} - {4'd0, w_pop};
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Reset empties the FIFO by clearing
    // the pointers and level, so any stale data is never read.
    if (w_push) r_mem[r_wr_ptr] <= rxByte;
  end

  // Statistics: accepted frames wrap at 255; lost frames saturate at 255.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_rx_count   <= 8'd0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_push) r_rx_count <= r_rx_count + 8'd1;
      r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

endmodule
